// File: rtl/serial_magcomp_ctrl.sv
// Serial MSB-first magnitude compare sequencer that time-shares one external
// 1-bit comparator cell and returns a registered AGB/AEB/ALB verdict.
module serial_magcomp_ctrl #(
    parameter int unsigned WIDTH      = 8,
    parameter bit          EARLY_EXIT = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             cmp_a,
    output logic             cmp_b,
    input  logic             cmp_agb,
    input  logic             cmp_aeb,
    input  logic             cmp_alb,
    output logic             busy,
    output logic             done,
    output logic             agb,
    output logic             aeb,
    output logic             alb,
    output logic             err
);

    localparam int unsigned IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_DONE
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] cap_a, cap_a_nxt;
    logic [WIDTH-1:0] cap_b, cap_b_nxt;
    logic [IW-1:0]    idx, idx_nxt;
    logic             pend_vld, pend_vld_nxt;
    logic             pend_agb, pend_agb_nxt;
    logic             agb_nxt, aeb_nxt, alb_nxt, err_nxt;
    logic             busy_nxt, done_nxt;
    logic             resp_onehot;
    logic             finish;

    // Bit pair for the shared comparator; quiet outside SCAN
    assign cmp_a = (state == S_SCAN) && cap_a[idx];
    assign cmp_b = (state == S_SCAN) && cap_b[idx];

    assign resp_onehot = ({cmp_agb, cmp_aeb, cmp_alb} == 3'b100) ||
                         ({cmp_agb, cmp_aeb, cmp_alb} == 3'b010) ||
                         ({cmp_agb, cmp_aeb, cmp_alb} == 3'b001);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            cap_a    <= '0;
            cap_b    <= '0;
            idx      <= IW'(WIDTH - 1);
            pend_vld <= 1'b0;
            pend_agb <= 1'b0;
            agb      <= 1'b0;
            aeb      <= 1'b0;
            alb      <= 1'b0;
            err      <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_nxt;
            cap_a    <= cap_a_nxt;
            cap_b    <= cap_b_nxt;
            idx      <= idx_nxt;
            pend_vld <= pend_vld_nxt;
            pend_agb <= pend_agb_nxt;
            agb      <= agb_nxt;
            aeb      <= aeb_nxt;
            alb      <= alb_nxt;
            err      <= err_nxt;
            busy     <= busy_nxt;
            done     <= done_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        cap_a_nxt    = cap_a;
        cap_b_nxt    = cap_b;
        idx_nxt      = idx;
        pend_vld_nxt = pend_vld;
        pend_agb_nxt = pend_agb;
        agb_nxt      = agb;
        aeb_nxt      = aeb;
        alb_nxt      = alb;
        err_nxt      = err;
        busy_nxt     = 1'b0;
        done_nxt     = 1'b0;
        finish       = 1'b0;

        case (state)
            S_IDLE, S_DONE: begin
                state_nxt = S_IDLE;
                if (start) begin
                    cap_a_nxt    = a;
                    cap_b_nxt    = b;
                    idx_nxt      = IW'(WIDTH - 1);
                    err_nxt      = 1'b0;
                    pend_vld_nxt = 1'b0;
                    pend_agb_nxt = 1'b0;
                    state_nxt    = S_SCAN;
                    busy_nxt     = 1'b1;
                end
            end
            S_SCAN: begin
                busy_nxt = 1'b1;
                if (!resp_onehot) begin
                    err_nxt = 1'b1;
                    agb_nxt = 1'b0;
                    aeb_nxt = 1'b0;
                    alb_nxt = 1'b0;
                    finish  = 1'b1;
                end else if (cmp_agb || cmp_alb) begin
                    if (EARLY_EXIT) begin
                        agb_nxt = cmp_agb;
                        alb_nxt = cmp_alb;
                        aeb_nxt = 1'b0;
                        finish  = 1'b1;
                    end else begin
                        // Keep only the first unequal verdict; scan runs to bit 0
                        if (!pend_vld) begin
                            pend_vld_nxt = 1'b1;
                            pend_agb_nxt = cmp_agb;
                        end
                        if (idx == '0) begin
                            agb_nxt = pend_vld ? pend_agb : cmp_agb;
                            alb_nxt = pend_vld ? !pend_agb : cmp_alb;
                            aeb_nxt = 1'b0;
                            finish  = 1'b1;
                        end else begin
                            idx_nxt = idx - IW'(1);
                        end
                    end
                end else if (idx == '0) begin
                    agb_nxt = pend_vld && pend_agb;
                    alb_nxt = pend_vld && !pend_agb;
                    aeb_nxt = !pend_vld;
                    finish  = 1'b1;
                end else begin
                    idx_nxt = idx - IW'(1);
                end

                if (finish) begin
                    state_nxt = S_DONE;
                    busy_nxt  = 1'b0;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_serial_magcomp_ctrl.sv
// Scoreboard bench for serial_magcomp_ctrl: one early-exit and one full-scan
// instance, each driving a behavioural 1-bit comparator with fault injection.
module tb_serial_magcomp_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    int         cyc = 0;
    int         n_checks = 0;
    int         n_pass = 0;

    // index 1 = EARLY_EXIT 1, index 0 = EARLY_EXIT 0
    logic       start_v[2];
    logic [7:0] a_v[2];
    logic [7:0] b_v[2];
    logic       ca[2], cb[2];
    logic       agbi[2], aebi[2], albi[2];
    logic       busy_v[2], done_v[2], agb_v[2], aeb_v[2], alb_v[2], err_v[2];
    int         fault_cyc[2];

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        int         c0;
        int         done_cyc;
        logic [3:0] res;
    } exp_t;

    exp_t q[2][$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural comparator cell, with a forced non-one-hot response on request
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            if (fault_cyc[i] == cyc) begin
                {agbi[i], aebi[i], albi[i]} = 3'b101;
            end else begin
                agbi[i] = ca[i] & ~cb[i];
                aebi[i] = ca[i] ~^ cb[i];
                albi[i] = ~ca[i] & cb[i];
            end
        end
    end

    serial_magcomp_ctrl #(.WIDTH(8), .EARLY_EXIT(1'b1)) u_dut_ee (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .a(a_v[1]), .b(b_v[1]),
        .cmp_a(ca[1]), .cmp_b(cb[1]),
        .cmp_agb(agbi[1]), .cmp_aeb(aebi[1]), .cmp_alb(albi[1]),
        .busy(busy_v[1]), .done(done_v[1]),
        .agb(agb_v[1]), .aeb(aeb_v[1]), .alb(alb_v[1]), .err(err_v[1])
    );

    serial_magcomp_ctrl #(.WIDTH(8), .EARLY_EXIT(1'b0)) u_dut_full (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .a(a_v[0]), .b(b_v[0]),
        .cmp_a(ca[0]), .cmp_b(cb[0]),
        .cmp_agb(agbi[0]), .cmp_aeb(aebi[0]), .cmp_alb(albi[0]),
        .busy(busy_v[0]), .done(done_v[0]),
        .agb(agb_v[0]), .aeb(aeb_v[0]), .alb(alb_v[0]), .err(err_v[0])
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    // Expected verdict and done cycle from the operands alone
    function automatic exp_t predict(input int ee, input logic [7:0] a, input logic [7:0] b,
                                     input int c0, input int fk);
        exp_t e;
        int   p;
        int   n;
        p = -1;
        for (int i = 7; i >= 0; i--) if (p < 0 && a[i] != b[i]) p = i;
        if (p < 0) begin
            n     = 8;
            e.res = 4'b0100;
        end else begin
            n     = (ee != 0) ? 8 - p : 8;
            e.res = a[p] ? 4'b1000 : 4'b0010;
        end
        if (fk > 0 && fk <= n) begin
            n     = fk;
            e.res = 4'b0001;
        end
        e.a        = a;
        e.b        = b;
        e.c0       = c0;
        e.done_cyc = c0 + n + 1;
        return e;
    endfunction

    // Call right after a negedge; returns right after the following negedge
    task automatic launch(input int s, input logic [7:0] a, input logic [7:0] b, input int fk);
        start_v[s]   = 1'b1;
        a_v[s]       = a;
        b_v[s]       = b;
        fault_cyc[s] = (fk > 0) ? cyc + fk : -1;
        q[s].push_back(predict(s, a, b, cyc, fk));
        @(negedge clk);
        start_v[s] = 1'b0;
    endtask

    task automatic wait_idle(input int s);
        int budget;
        budget = 40;
        while (q[s].size() != 0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        chk("done_timeout", 32'(q[s].size()), 32'd0);
    endtask

    // Monitor: bit-pair tracking while busy, pop and compare on done
    always @(negedge clk) begin
        exp_t f;
        int   k;
        if (rst_n) begin
            for (int i = 0; i < 2; i++) begin
                if (busy_v[i] && q[i].size() != 0) begin
                    f = q[i][0];
                    k = cyc - f.c0;
                    if (k >= 1 && k <= 8) begin
                        chk("cmp_a_bit", 32'(ca[i]), 32'(f.a[8-k]));
                        chk("cmp_b_bit", 32'(cb[i]), 32'(f.b[8-k]));
                    end
                end
                if (done_v[i]) begin
                    if (q[i].size() == 0) begin
                        chk("spurious_done", 32'd1, 32'd0);
                    end else begin
                        f = q[i].pop_front();
                        chk("done_cycle", 32'(cyc - f.c0), 32'(f.done_cyc - f.c0));
                        chk("result_agb_aeb_alb_err",
                            32'({agb_v[i], aeb_v[i], alb_v[i], err_v[i]}), 32'(f.res));
                    end
                end
            end
        end
    end

    initial begin
        rst_n     = 1'b0;
        start_v   = '{1'b0, 1'b0};
        a_v       = '{8'h00, 8'h00};
        b_v       = '{8'h00, 8'h00};
        fault_cyc = '{-1, -1};
        repeat (2) @(negedge clk);
        for (int i = 0; i < 2; i++)
            chk("reset_outputs", 32'({busy_v[i], done_v[i], agb_v[i], aeb_v[i], alb_v[i],
                                      err_v[i], ca[i], cb[i]}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Early-exit instance
        launch(1, 8'h80, 8'h7F, 0);
        wait_idle(1);
        repeat (2) @(negedge clk);
        chk("result_hold_idle", 32'({agb_v[1], aeb_v[1], alb_v[1], err_v[1]}), 32'h8);
        launch(1, 8'h55, 8'h55, 0);
        wait_idle(1);
        launch(1, 8'h12, 8'h13, 0);
        wait_idle(1);

        // start while busy with new operands must be ignored
        launch(1, 8'h55, 8'h54, 0);
        repeat (2) @(negedge clk);
        start_v[1] = 1'b1;
        a_v[1]     = 8'h00;
        b_v[1]     = 8'hFF;
        @(negedge clk);
        start_v[1] = 1'b0;
        wait_idle(1);

        // start held in the DONE cycle chains a second compare
        launch(1, 8'h80, 8'h7F, 0);
        @(negedge clk);
        chk("done_before_chain", 32'(done_v[1]), 32'd1);
        launch(1, 8'h01, 8'h02, 0);
        wait_idle(1);

        // Non-one-hot response on the second scanned bit
        launch(1, 8'h55, 8'h55, 2);
        wait_idle(1);
        launch(1, 8'hA0, 8'hA0, 0);
        wait_idle(1);

        // Reset in cycle 4 of a compare aborts it with no done pulse
        launch(1, 8'h55, 8'h54, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_outputs", 32'({busy_v[1], done_v[1], agb_v[1], aeb_v[1], alb_v[1],
                                  err_v[1], ca[1], cb[1]}), 32'd0);
        q[1].delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        launch(1, 8'h01, 8'h00, 0);
        wait_idle(1);

        // Full-scan instance
        launch(0, 8'hF0, 8'h0F, 0);
        wait_idle(0);
        launch(0, 8'h12, 8'h13, 0);
        wait_idle(0);
        launch(0, 8'h83, 8'h05, 0);
        wait_idle(0);
        launch(0, 8'h55, 8'h55, 3);
        wait_idle(0);
        launch(0, 8'h3C, 8'h3C, 0);
        wait_idle(0);

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 32'(q[0].size() + q[1].size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/serial_magcomp_ctrl.md
Name: serial_magcomp_ctrl

Overview:
- Sequencer that compares two WIDTH-bit operands serially, MSB first, by time-sharing one external 1-bit magnitude comparator.
- Each cycle it drives one bit pair to the comparator and samples that comparator's one-hot AGB/AEB/ALB response.
- It stops at the first unequal bit and reports a registered WIDTH-bit AGB/AEB/ALB result with a start/done handshake.
- Sits between operand producers and the shared 1-bit comparator cell in the combinational library.

Parameters:
- WIDTH, 8, operand width in bits; legal range 2..32.
- EARLY_EXIT, 1, 1 = finish at the first unequal bit; 0 = always scan all WIDTH bits and keep the first unequal verdict.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request a compare; sampled only in IDLE or DONE.
- a  input  WIDTH  operand A; captured on the accepted start edge.
- b  input  WIDTH  operand B; captured on the accepted start edge.
- cmp_a  output  1  bit of captured A at the current index, to the 1-bit comparator.
- cmp_b  output  1  bit of captured B at the current index, to the 1-bit comparator.
- cmp_agb  input  1  comparator response: greater (combinational, same cycle).
- cmp_aeb  input  1  comparator response: equal.
- cmp_alb  input  1  comparator response: less.
- busy  output  1  high while in SCAN.
- done  output  1  one-cycle pulse; result valid.
- agb  output  1  registered result, A > B.
- aeb  output  1  registered result, A == B.
- alb  output  1  registered result, A < B.
- err  output  1  comparator returned a non-one-hot response during the last compare.

Behaviour:
- Reset (rst_n low, asynchronous): state = IDLE.
  - busy, done, agb, aeb, alb and err all = 0.
  - Captured operands = 0; index = WIDTH-1.
  - cmp_a and cmp_b = 0.
- States: IDLE, SCAN, DONE.
- IDLE:
  - start = 1 captures a and b, sets index = WIDTH-1, clears err, and moves to SCAN.
  - Result outputs hold their previous values.
- SCAN (busy = 1):
  - cmp_a = capA[index] and cmp_b = capB[index], combinationally from registers.
  - The response is sampled at the end of the same cycle.
- Per SCAN cycle, in priority order:
  1. Response not one-hot (zero bits or more than one bit set): err <= 1, agb/aeb/alb <= 0, go to DONE.
  2. cmp_agb or cmp_alb, with EARLY_EXIT = 1: agb <= cmp_agb, alb <= cmp_alb, aeb <= 0, go to DONE.
  3. cmp_agb or cmp_alb, with EARLY_EXIT = 0: the first unequal bit's verdict is latched in a pending flag; later bits are ignored except for the one-hot check. Continue until index = 0.
  4. cmp_aeb with index = 0: output the pending verdict if one exists, else aeb <= 1. Go to DONE.
  5. cmp_aeb with index > 0: index <= index-1.
- DONE:
  - done = 1 for exactly one cycle, busy = 0.
  - Results (agb, aeb, alb, err) are stable from this cycle until the next accepted start.
  - Next state is IDLE; if start = 1 in DONE, it is accepted as in IDLE and the next state is SCAN (back-to-back compares).
- Latency: start sampled at the end of cycle 0; SCAN occupies cycles 1..n; done is high in cycle n+1.
  - EARLY_EXIT = 1: n = (WIDTH-1-p)+1, where p is the highest unequal bit position; n = WIDTH when the operands are equal.
  - EARLY_EXIT = 0: n = WIDTH always.
- start while in SCAN is ignored; changes to a and b after capture have no effect.
- Exactly one of agb/aeb/alb is 1 after a compare, unless err = 1, in which case all three are 0.
- Reset asserted mid-SCAN aborts immediately to the reset values; no done pulse is issued.
- cmp_* inputs are ignored outside SCAN.

Test Plan:
- WIDTH = 8, EARLY_EXIT = 1, a = 0x80, b = 0x7F, start in cycle 0 -> one SCAN cycle; done in cycle 2 with agb = 1, aeb = 0, alb = 0, err = 0.
- a = 0x55, b = 0x55 -> 8 SCAN cycles with cmp_a/cmp_b following bits 7..0; done in cycle 9 with aeb = 1.
- a = 0x12, b = 0x13 -> differs only at bit 0; done in cycle 9 with alb = 1. Repeat with EARLY_EXIT = 0 and a = 0xF0, b = 0x0F -> done in cycle 9 with agb = 1.
- Start re-asserted in cycle 3 while busy, with new a/b -> ignored; the result matches the original operands. Start held in the DONE cycle -> a new SCAN begins the next cycle.
- Bench forces cmp_agb = cmp_alb = 1 at the second scanned bit -> err = 1, agb/aeb/alb = 0, done in cycle 3.
- rst_n pulled low in cycle 4 of a compare -> all outputs 0 asynchronously, no done pulse. After release, a new compare of 0x01 vs 0x00 gives agb = 1 in 9 cycles.
